// File: rtl/multdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_pkg
// Purpose  : Shared types and constants for the multiply/divide sequencer
//            and its iterative engine.
// Revision : 1.0  initial release
// ============================================================================
package multdiv_pkg;

  // Default datapath geometry
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_CNT_W      = $clog2(DEF_DATA_WIDTH);

  // ALU opcodes understood by the engine
  localparam logic [4:0] ALU_MULT = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True when the opcode selects the divider
  function automatic logic is_div_op(input logic [4:0] op);
    return (op == ALU_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/multdiv_engine.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_engine
// Purpose  : Iterative signed datapath. Unsigned shift-add multiplier and
//            restoring divider on operand magnitudes, with a final sign
//            fix-up. One bit per step; DATA_WIDTH steps per operation.
// Revision : 1.0  initial release
// ============================================================================
module multdiv_engine
  import multdiv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic [4:0]            op,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow
);

  localparam int W = DATA_WIDTH;

  // Shared working registers:
  //   multiply: hi = partial-product accumulator, lo = multiplier shifting out,
  //             opnd = multiplicand magnitude
  //   divide  : hi = partial remainder, lo = dividend shifting out / quotient
  //             shifting in, opnd = divisor magnitude
  logic         is_div;
  logic         neg;
  logic         dbz;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [W-1:0] opnd;

  logic [W-1:0] mag_a;
  logic [W-1:0] mag_b;
  logic         load_div;

  logic [W:0]   mul_sum;
  logic [W:0]   div_shift;
  logic         div_ok;
  logic [W-1:0] div_sub;

  logic [2*W-1:0] prod_u;
  logic [2*W-1:0] prod_s;
  logic [W-1:0]   quot_s;

  // Operand magnitudes; the most negative value maps to 2^(W-1) unsigned
  assign mag_a    = op_a[W-1] ? (~op_a + {{(W-1){1'b0}}, 1'b1}) : op_a;
  assign mag_b    = op_b[W-1] ? (~op_b + {{(W-1){1'b0}}, 1'b1}) : op_b;
  assign load_div = is_div_op(op);

  // Multiply step: conditionally add multiplicand, then shift {hi,lo} right
  assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(W+1){1'b0}});

  // Divide step: shift next dividend bit into the remainder and trial-subtract.
  // When the subtraction succeeds the true difference is below 2^W, so the
  // modular W-bit difference is exact.
  assign div_shift = {hi, lo[W-1]};
  assign div_ok    = (div_shift >= {1'b0, opnd});
  assign div_sub   = div_shift[W-1:0] - opnd;

  // Iteration registers: load on issue, advance one bit per step
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      is_div <= 1'b0;
      neg    <= 1'b0;
      dbz    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      opnd   <= '0;
    end else if (load) begin
      is_div <= load_div;
      neg    <= op_a[W-1] ^ op_b[W-1];
      dbz    <= load_div && (op_b == '0);
      hi     <= '0;
      lo     <= load_div ? mag_a : mag_b;
      opnd   <= load_div ? mag_b : mag_a;
    end else if (step) begin
      if (is_div) begin
        hi <= div_ok ? div_sub : div_shift[W-1:0];
        lo <= {lo[W-2:0], div_ok};
      end else begin
        hi <= mul_sum[W:1];
        lo <= {mul_sum[0], lo[W-1:1]};
      end
    end
  end

  // Sign fix-up of the unsigned results
  assign prod_u = {hi, lo};
  assign prod_s = neg ? (~prod_u + {{(2*W-1){1'b0}}, 1'b1}) : prod_u;
  assign quot_s = neg ? (~lo + {{(W-1){1'b0}}, 1'b1}) : lo;

  // Result select and exception detection
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    if (is_div) begin
      if (dbz) begin
        result   = '0;
        overflow = 1'b1;
      end else begin
        result   = quot_s;
        // A positive quotient with the top bit set only arises from MIN / -1
        overflow = !neg && lo[W-1];
      end
    end else begin
      result   = prod_s[W-1:0];
      overflow = (prod_s[2*W-1:W] != {W{prod_s[W-1]}});
    end
  end

endmodule
`default_nettype wire

// File: rtl/multdiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_sequencer
// Purpose  : Execute-stage controller for the shared multiply/divide engine.
//            Freezes the front of the pipeline while the engine iterates and
//            hands result, destination and exception to X/M as a one-cycle
//            valid pulse. A flush aborts the operation without a result.
// Revision : 1.0  initial release
// ============================================================================
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ctrl_mult,
  input  logic                  ctrl_div,
  input  logic [DATA_WIDTH-1:0] operandA,
  input  logic [DATA_WIDTH-1:0] operandB,
  input  logic [REG_ADDR_W-1:0] dest_reg,
  input  logic                  flush,
  output logic                  stall_pipe,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] result,
  output logic [REG_ADDR_W-1:0] result_rd,
  output logic                  result_valid,
  output logic                  exception
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

  state_e state;
  state_e state_nxt;

  logic [CW-1:0]         counter;
  logic [REG_ADDR_W-1:0] rd_latch;

  // Values presented while no result is being delivered
  logic [DATA_WIDTH-1:0] hold_result;
  logic [REG_ADDR_W-1:0] hold_rd;
  logic                  hold_exc;

  logic                  start;
  logic                  start_dbz;
  logic [4:0]            issue_op;
  logic [DATA_WIDTH-1:0] eng_result;
  logic                  eng_overflow;

  // Issue qualification: only from IDLE, flush wins, multiply beats divide
  assign start     = (ctrl_mult | ctrl_div) && (state == ST_IDLE) && !flush;
  assign issue_op  = ctrl_mult ? ALU_MULT : ALU_DIV;
  assign start_dbz = start && !ctrl_mult && (operandB == '0);

  multdiv_engine #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_engine (
    .clock    (clock),
    .reset    (reset),
    .load     (start),
    .step     (state == ST_RUN),
    .op       (issue_op),
    .op_a     (operandA),
    .op_b     (operandB),
    .result   (eng_result),
    .overflow (eng_overflow)
  );

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = start_dbz ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_nxt = ST_IDLE;
        end else if (counter == LAST_CNT) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register and iteration counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      counter <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_RUN && state_nxt == ST_RUN) begin
        counter <= counter + CW'(1);
      end else begin
        counter <= '0;
      end
    end
  end

  // Destination register captured with the issuing instruction
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_latch <= '0;
    end else if (start) begin
      rd_latch <= dest_reg;
    end
  end

  // Remember the last delivered result so outputs hold between pulses
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_result <= '0;
      hold_rd     <= '0;
      hold_exc    <= 1'b0;
    end else if (result_valid) begin
      hold_result <= eng_result;
      hold_rd     <= rd_latch;
      hold_exc    <= eng_overflow;
    end
  end

  // Handshake outputs; a flush in DONE suppresses the pulse
  assign result_valid = (state == ST_DONE) && !flush;
  assign busy         = (state == ST_RUN);
  assign stall_pipe   = start || (state == ST_RUN);
  assign result       = result_valid ? eng_result   : hold_result;
  assign result_rd    = result_valid ? rd_latch     : hold_rd;
  assign exception    = result_valid ? eng_overflow : hold_exc;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multdiv_sequencer
// Purpose  : Self-checking bench for multdiv_sequencer. Expected results are
//            pushed to a scoreboard at issue and popped on result_valid.
// Revision : 1.0  initial release
// ============================================================================
module tb_multdiv_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ctrl_mult = 1'b0;
  logic        ctrl_div = 1'b0;
  logic [31:0] operandA = '0;
  logic [31:0] operandB = '0;
  logic [4:0]  dest_reg = '0;
  logic        flush = 1'b0;
  logic        stall_pipe;
  logic        busy;
  logic [31:0] result;
  logic [4:0]  result_rd;
  logic        result_valid;
  logic        exception;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        exc;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          failed = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd = '0;
  logic        last_exc = 1'b0;

  multdiv_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .ctrl_mult    (ctrl_mult),
    .ctrl_div     (ctrl_div),
    .operandA     (operandA),
    .operandB     (operandB),
    .dest_reg     (dest_reg),
    .flush        (flush),
    .stall_pipe   (stall_pipe),
    .busy         (busy),
    .result       (result),
    .result_rd    (result_rd),
    .result_valid (result_valid),
    .exception    (exception)
  );

  always #5 clock = ~clock;

  // Reference model: {exception, result}
  function automatic logic [32:0] model_op(input logic is_mult, input logic [31:0] a,
                                           input logic [31:0] b);
    longint      p;
    logic [63:0] pv;
    logic [31:0] q;
    if (is_mult) begin
      p  = longint'($signed(a)) * longint'($signed(b));
      pv = p;
      return {(pv[63:32] != {32{pv[31]}}), pv[31:0]};
    end
    if (b == 32'h0) return {1'b1, 32'h0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, a};
    q = $signed(a) / $signed(b);
    return {1'b0, q};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one operation now and follow it to its result pulse
  task automatic run_op(input logic m, input logic d, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int exp_lat,
                        input string name);
    exp_t        e;
    exp_t        got;
    logic [32:0] mo;
    int          lat;
    int          bad;
    mo = model_op(m, a, b);
    e.res = mo[31:0];
    e.rd  = rd;
    e.exc = mo[32];
    sb.push_back(e);
    ctrl_mult = m; ctrl_div = d; operandA = a; operandB = b; dest_reg = rd;
    bad = 0;
    lat = -1;
    @(negedge clock);
    if (stall_pipe !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0) bad++;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 1) begin
        ctrl_mult = 1'b0; ctrl_div = 1'b0; dest_reg = ~rd;
        operandA = ~a; operandB = 32'h0;
      end
      @(negedge clock);
      if (result_valid === 1'b1) begin
        lat = c;
        break;
      end
      if (stall_pipe !== 1'b1 || busy !== 1'b1) bad++;
    end
    tests++;
    if (bad != 0) begin
      failed++;
      $display("FAIL %s stall/busy: %0d bad cycles, required 0", name, bad);
    end
    tests++;
    if (lat != exp_lat) begin
      failed++;
      $display("FAIL %s latency: got %0d, required %0d", name, lat, exp_lat);
    end
    if (lat < 0) begin
      void'(sb.pop_front());
      return;
    end
    got = '{res: result, rd: result_rd, exc: exception};
    e = sb.pop_front();
    tests++;
    if (got !== e) begin
      failed++;
      $display("FAIL %s result: got res=%h rd=%0d exc=%b, required res=%h rd=%0d exc=%b",
               name, got.res, got.rd, got.exc, e.res, e.rd, e.exc);
    end
    tests++;
    if (stall_pipe !== 1'b0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL %s done-cycle stall=%b busy=%b, required 0 0", name, stall_pipe, busy);
    end
    last_res = e.res; last_rd = e.rd; last_exc = e.exc;
  endtask

  // Count result pulses over a window; any pulse is a failure
  task automatic expect_quiet(input int cycles, input string name);
    int pulses;
    pulses = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clock);
      if (result_valid !== 1'b0) pulses++;
      @(posedge clock);
      #1;
    end
    tests++;
    if (pulses != 0) begin
      failed++;
      $display("FAIL %s: %0d result_valid pulses, required 0", name, pulses);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    tests++;
    if ({stall_pipe, busy, result, result_rd, result_valid, exception} !== '0) begin
      failed++;
      $display("FAIL %s: stall=%b busy=%b res=%h rd=%0d valid=%b exc=%b, required all 0",
               name, stall_pipe, busy, result, result_rd, result_valid, exception);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    check_zero_outputs("reset_state");
    reset = 1'b1;
    tick();
    check_zero_outputs("post_reset_idle");
  endtask

  task automatic test_mult();
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA, 5'd3, 33, "mult_7x-6");
    tick();
    run_op(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd5, 5'd14, 33, "mult_both_flags");
    tick();
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 33, "mult_min_x_-1");
  endtask

  task automatic test_back_to_back();
    tick();
    run_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd7, 33, "mult_overflow");
    // Issue during DONE must be ignored
    ctrl_mult = 1'b1; operandA = 32'd11; operandB = 32'd13; dest_reg = 5'd8;
    #1;
    tests++;
    if (stall_pipe !== 1'b0) begin
      failed++;
      $display("FAIL b2b_done_issue stall=%b, required 0", stall_pipe);
    end
    tick();
    run_op(1'b1, 1'b0, 32'd11, 32'd13, 5'd8, 33, "b2b_next_idle");
  endtask

  task automatic test_div();
    tick();
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd9, 33, "div_-7/2");
    tick();
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 33, "div_min/-1");
    tick();
    run_op(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 5'd11, 33, "div_100/-7");
  endtask

  task automatic test_div_zero();
    tick();
    run_op(1'b0, 1'b1, 32'd5, 32'd0, 5'd12, 1, "div_by_zero");
    tick();
    tests++;
    if (stall_pipe !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0) begin
      failed++;
      $display("FAIL dbz_back_to_idle stall=%b busy=%b valid=%b, required 0 0 0",
               stall_pipe, busy, result_valid);
    end
  endtask

  task automatic test_flush_done();
    ctrl_div = 1'b1; operandA = 32'd9; operandB = 32'd0; dest_reg = 5'd25;
    tick();
    ctrl_div = 1'b0;
    flush = 1'b1;
    #1;
    tests++;
    if (result_valid !== 1'b0 || result_rd !== last_rd || result !== last_res) begin
      failed++;
      $display("FAIL flush_in_done valid=%b rd=%0d res=%h, required 0 %0d %h",
               result_valid, result_rd, result, last_rd, last_res);
    end
    tick();
    flush = 1'b0;
    expect_quiet(3, "flush_done_quiet");
  endtask

  task automatic test_flush();
    ctrl_mult = 1'b1; operandA = 32'd6; operandB = 32'd6; dest_reg = 5'd30;
    tick();
    ctrl_mult = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clock);
    tests++;
    if (stall_pipe !== 1'b0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL flush_run stall=%b busy=%b, required 0 0", stall_pipe, busy);
    end
    tick();
    expect_quiet(40, "flush_run_quiet");
    tests++;
    if (result_rd !== last_rd || exception !== last_exc) begin
      failed++;
      $display("FAIL flush_hold rd=%0d exc=%b, required %0d %b", result_rd, exception,
               last_rd, last_exc);
    end
    // Flush together with an issue: nothing starts
    ctrl_div = 1'b1; flush = 1'b1; operandA = 32'd40; operandB = 32'd4; dest_reg = 5'd2;
    @(negedge clock);
    tests++;
    if (stall_pipe !== 1'b0) begin
      failed++;
      $display("FAIL flush_issue stall=%b, required 0", stall_pipe);
    end
    tick();
    ctrl_div = 1'b0; flush = 1'b0;
    tests++;
    if (busy !== 1'b0) begin
      failed++;
      $display("FAIL flush_issue_busy busy=%b, required 0", busy);
    end
    expect_quiet(40, "flush_issue_quiet");
  endtask

  task automatic test_reset_mid();
    ctrl_mult = 1'b1; operandA = 32'd123; operandB = 32'd456; dest_reg = 5'd17;
    tick();
    ctrl_mult = 1'b0;
    repeat (14) tick();
    #3;
    reset = 1'b0;
    #1;
    check_zero_outputs("reset_mid_op");
    tick();
    reset = 1'b1;
    expect_quiet(40, "reset_mid_quiet");
    run_op(1'b1, 1'b0, 32'd3, 32'd4, 5'd4, 33, "mult_after_reset");
  endtask

  initial begin
    test_reset();
    test_mult();
    test_back_to_back();
    test_div();
    test_div_zero();
    test_flush_done();
    test_flush();
    test_reset_mid();
    tests++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_empty: %0d left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
